// File: rtl/fcs_check_pkg.sv
// rtl/fcs_check_pkg.sv - shared FCS helpers, verdict codes and checker FSM encoding
package fcs_check_pkg;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_CRC  = 2'd1;
  localparam logic [1:0] ST_RUNT = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECV     = 2'd1,
    S_WAIT_CRC = 2'd2
  } state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Per-byte reverse-and-invert; applying it twice yields the original word.
  function automatic logic [31:0] fcs_map(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ~bitrev8(w[8*k +: 8]);
    return r;
  endfunction

endpackage

// File: rtl/fcs_sat_counter.sv
// rtl/fcs_sat_counter.sv - saturating event counter
module fcs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fcs_check.sv
// rtl/fcs_check.sv - receive FCS capture, register-domain compare and frame verdicts
module fcs_check
  import fcs_check_pkg::*;
#(
  parameter int MIN_LEN = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic             sop,
  input  logic             eop,
  input  logic             crc_valid,
  input  logic [31:0]      crc_in,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic [1:0]       chk_status,
  output logic [31:0]      rx_fcs_reg,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int LW = $clog2(MIN_LEN + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e        state_q, state_d;
  logic [31:0]   fcs_sh_q, fcs_sh_d;
  logic [31:0]   map_q, map_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   rx_map;

  logic          v_d;
  logic [1:0]    st_d;
  logic [31:0]   fcs_d;

  logic          chk_valid_q, chk_ok_q;
  logic [1:0]    chk_status_q;
  logic [31:0]   rx_fcs_q;

  assign fcs_sh_d = data_valid ? {fcs_sh_q[23:0], data_in} : fcs_sh_q;
  assign rx_map   = fcs_map(fcs_sh_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    map_d   = map_q;
    v_d     = 1'b0;
    st_d    = ST_OK;
    fcs_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (data_valid && sop) begin
          if (eop) begin
            v_d  = 1'b1;
            st_d = ST_RUNT;
          end else begin
            state_d = S_RECV;
            cnt_d   = LW'(1);
          end
        end
      end
      S_RECV: begin
        if (data_valid) begin
          if (sop) begin
            // New frame overlaps an unterminated one: abort the old, keep receiving
            v_d   = 1'b1;
            st_d  = ST_TMO;
            fcs_d = rx_map;
            cnt_d = LW'(1);
          end else if (eop) begin
            if (cnt_q < LW'(MIN_LEN - 1)) begin
              v_d     = 1'b1;
              st_d    = ST_RUNT;
              state_d = S_IDLE;
            end else if (crc_valid) begin
              v_d     = 1'b1;
              st_d    = (rx_map == crc_in) ? ST_OK : ST_CRC;
              fcs_d   = rx_map;
              state_d = S_IDLE;
            end else begin
              map_d   = rx_map;
              tmr_d   = '0;
              state_d = S_WAIT_CRC;
            end
          end else if (cnt_q != LW'(MIN_LEN)) begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      S_WAIT_CRC: begin
        if (crc_valid) begin
          v_d     = 1'b1;
          st_d    = (map_q == crc_in) ? ST_OK : ST_CRC;
          fcs_d   = map_q;
          state_d = S_IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          v_d     = 1'b1;
          st_d    = ST_TMO;
          fcs_d   = map_q;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
        if (data_valid && sop) begin
          if (!v_d) begin
            v_d   = 1'b1;
            st_d  = ST_TMO;
            fcs_d = map_q;
          end
          state_d = S_RECV;
          cnt_d   = LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fcs_sh_q     <= '0;
      map_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      chk_valid_q  <= 1'b0;
      chk_ok_q     <= 1'b0;
      chk_status_q <= ST_OK;
      rx_fcs_q     <= '0;
    end else begin
      state_q     <= state_d;
      fcs_sh_q    <= fcs_sh_d;
      map_q       <= map_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      chk_valid_q <= v_d;
      if (v_d) begin
        chk_ok_q     <= (st_d == ST_OK);
        chk_status_q <= st_d;
        rx_fcs_q     <= fcs_d;
      end
    end
  end

  fcs_sat_counter #(.W(CNT_W)) u_good (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (v_d && (st_d == ST_OK)),
    .cnt_o (good_cnt)
  );

  fcs_sat_counter #(.W(CNT_W)) u_bad (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (v_d && (st_d != ST_OK)),
    .cnt_o (bad_cnt)
  );

  assign chk_valid  = chk_valid_q;
  assign chk_ok     = chk_ok_q;
  assign chk_status = chk_status_q;
  assign rx_fcs_reg = rx_fcs_q;

endmodule
